// File: rtl/clmul_unit.sv
// clmul_unit: iterative carry-less multiplier (clmul / clmulh / clmulr).
// One partial product is folded into a 2*WIDTH accumulator per cycle, so the
// latency is always WIDTH cycles regardless of operand values.
module clmul_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;

    logic             w_accept;
    logic [AW-1:0]    w_partial;
    logic [WIDTH-1:0] w_y;

    assign in_ready  = (r_state == S_IDLE) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign y         = w_y;

    // Partial product for the current multiplier bit: a shifted into place, or zero
    assign w_partial = r_b[r_cnt] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;

    // Control FSM and datapath: reset beats flush, flush beats the handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
        end else if (flush && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc <= r_acc ^ w_partial;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result slice selection; forced to zero whenever no result is presented
    always_comb begin
        w_y = '0;
        if (r_state == S_DONE) begin
            case (r_op)
                2'b00:   w_y = r_acc[WIDTH-1:0];
                2'b01:   w_y = r_acc[AW-1:WIDTH];
                2'b10:   w_y = r_acc[AW-2:WIDTH-1];
                default: w_y = '0;
            endcase
        end
    end

endmodule
